// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO input capture block.
package gpio_pkg;

    localparam int GPIO_WIDTH = 32;

    typedef enum logic [1:0] {
        EM_NONE = 2'b00,
        EM_RISE = 2'b01,
        EM_FALL = 2'b10,
        EM_BOTH = 2'b11
    } edge_mode_t;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } cap_state_t;

endpackage

// File: rtl/gpio_in_capture_sync.sv
// Multi-bit flop-chain synchronizer; dout is the last stage.
module gpio_sync_chain #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    // Next value of each stage is the previous stage (or the raw pins).
    always_comb begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            if (i == 0) begin
                stage_d[i] = din;
            end else begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_in_capture.sv
// Header-pin input capture: synchronize, detect edges, sticky flags, saturating
// counter, masked interrupt and a selectable display byte.
module gpio_in_capture
    import gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    localparam int SEL_W      = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1
) (
    input  logic             CLOCK_50,
    input  logic             RESETn,
    input  logic [WIDTH-1:0] GPIO_IN,
    input  logic [1:0]       EDGE_MODE,
    input  logic [SEL_W-1:0] BYTE_SEL,
    input  logic             CLR,
    input  logic [WIDTH-1:0] IRQ_MASK,
    output logic [WIDTH-1:0] gpio_sync,
    output logic [WIDTH-1:0] edge_flags,
    output logic [CNT_W-1:0] edge_count,
    output logic [7:0]       byte_out,
    output logic             ready,
    output logic             irq
);

    localparam int PC_W   = $clog2(WIDTH + 1);
    localparam int SUM_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);
    localparam int NBYTES = WIDTH / 8;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    logic [WIDTH-1:0]  sync_s;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [WIDTH-1:0]  rise_s, fall_s, det_s;
    logic [WIDTH-1:0]  flags_q, flags_d;
    logic [CNT_W-1:0]  count_q, count_d, count_base_s;
    logic [SUM_W-1:0]  sum_s;
    logic [7:0]        byte_q, byte_d;
    logic              irq_q, irq_d;
    cap_state_t        state_q;
    logic [WARM_W-1:0] warm_cnt_q;
    logic              ready_q;

    gpio_sync_chain #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (CLOCK_50),
        .rst_n(RESETn),
        .din  (GPIO_IN),
        .dout (sync_s)
    );

    // Edge detection; suppressed during warm-up so the reset-time prev value
    // cannot masquerade as an edge.
    always_comb begin
        rise_s = sync_s & ~prev_q;
        fall_s = ~sync_s & prev_q;
        det_s  = {WIDTH{1'b0}};
        if (state_q == RUN) begin
            case (edge_mode_t'(EDGE_MODE))
                EM_NONE: det_s = {WIDTH{1'b0}};
                EM_RISE: det_s = rise_s;
                EM_FALL: det_s = fall_s;
                EM_BOTH: det_s = rise_s | fall_s;
                default: det_s = {WIDTH{1'b0}};
            endcase
        end else begin
            det_s = {WIDTH{1'b0}};
        end
    end

    // Next-state for prev, flags, counter, irq and display byte.
    always_comb begin
        prev_d  = sync_s;
        flags_d = (CLR ? {WIDTH{1'b0}} : flags_q) | det_s;
        count_base_s = CLR ? {CNT_W{1'b0}} : count_q;
        sum_s   = SUM_W'(count_base_s) + SUM_W'(popcount(det_s));
        if (|sum_s[SUM_W-1:CNT_W]) begin
            count_d = {CNT_W{1'b1}};
        end else begin
            count_d = sum_s[CNT_W-1:0];
        end
        irq_d  = |(flags_q & IRQ_MASK);
        byte_d = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (SEL_W'(i) == BYTE_SEL) begin
                byte_d = sync_s[8*i +: 8];
            end else begin
                byte_d = byte_d;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            prev_q  <= {WIDTH{1'b0}};
            flags_q <= {WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
            irq_q   <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            prev_q  <= prev_d;
            flags_q <= flags_d;
            count_q <= count_d;
            irq_q   <= irq_d;
            byte_q  <= byte_d;
        end
    end

    // Warm-up FSM: SYNC_STAGES+1 cycles in WARM, then RUN until reset.
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= WARM;
            warm_cnt_q <= {WARM_W{1'b0}};
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                WARM: begin
                    if (warm_cnt_q == WARM_W'(SYNC_STAGES)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + {{(WARM_W-1){1'b0}}, 1'b1};
                        ready_q    <= 1'b0;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= WARM;
                    warm_cnt_q <= {WARM_W{1'b0}};
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign gpio_sync  = sync_s;
    assign edge_flags = flags_q;
    assign edge_count = count_q;
    assign byte_out   = byte_q;
    assign ready      = ready_q;
    assign irq        = irq_q;

endmodule
